// File: rtl/scct_ccx_channel.sv
// SCCT capture/compare channel: filtered input capture into a FIFO, output compare,
// edge-aligned PWM and a four-register host interface.
module scct_ccx_channel #(
  parameter int unsigned CTR_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CTR_WIDTH-1:0] counter,
  input  logic                 counter_changed,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [1:0]           addr,
  input  logic [CTR_WIDTH-1:0] wr_data,
  output logic [CTR_WIDTH-1:0] rd_data,
  output logic                 irq_o,
  input  logic                 pin_i,
  output logic                 pin_o,
  output logic                 pin_oe
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;
  localparam int unsigned STAT_W = CNT_W + 3;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_CC     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_FORCE  = 2'd3;

  typedef enum logic [1:0] {
    MODE_IC  = 2'b00,
    MODE_OC  = 2'b01,
    MODE_PWM = 2'b10,
    MODE_OFF = 2'b11
  } mode_e;

  mode_e               mode;
  logic [1:0]          action;
  logic                irq_en;
  logic [CTR_WIDTH-1:0] cc_reg;
  logic                ocf;
  logic                ovf;

  logic [1:0]          sync;
  logic                filt;
  logic                filt_d;
  logic [FCNT_W-1:0]   filt_cnt;

  logic [CTR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  logic wr_ctrl, mode_chg, is_ic, is_oc, is_pwm;
  logic rise, fall, push_req, pop_req, full, do_push, ovf_set;
  logic oc_match, ctr_zero, force_hit, ocf_set, status_wr, icf;
  logic pin_o_nxt;
  logic [STAT_W-1:0] status_vec;

  assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
  assign mode_chg  = wr_ctrl && (wr_data[1:0] != mode);
  assign is_ic     = (mode == MODE_IC);
  assign is_oc     = (mode == MODE_OC);
  assign is_pwm    = (mode == MODE_PWM);
  assign rise      = filt && !filt_d;
  assign fall      = !filt && filt_d;
  assign push_req  = is_ic && !mode_chg && ((action[0] && rise) || (action[1] && fall));
  assign pop_req   = is_ic && rd_en && (addr == ADDR_CC) && (count != '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign do_push   = push_req && (!full || pop_req);
  assign ovf_set   = push_req && full && !pop_req;
  assign oc_match  = counter_changed && (counter == cc_reg);
  assign ctr_zero  = counter_changed && (counter == '0);
  assign force_hit = wr_en && (addr == ADDR_FORCE) && wr_data[0];
  assign ocf_set   = oc_match && (is_oc || is_pwm);
  assign status_wr = wr_en && (addr == ADDR_STATUS);
  assign icf       = (count != '0);
  assign status_vec = {count, ovf, ocf, icf};

  // Synchroniser and glitch filter; filt only moves after FILT_LEN agreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      filt     <= 1'b0;
      filt_d   <= 1'b0;
      filt_cnt <= '0;
    end else begin
      sync   <= {sync[0], pin_i};
      filt_d <= filt;
      if (sync[1] == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCNT_W'(FILT_LEN - 1)) begin
        filt     <= sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FCNT_W'(1);
      end
    end
  end

  // Capture FIFO; a mode change flushes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (mode_chg) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= counter;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_req) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop_req})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Output pin next value for compare and PWM modes.
  always_comb begin
    pin_o_nxt = pin_o;
    if (is_oc && (oc_match || force_hit)) begin
      case (action)
        2'b01:   pin_o_nxt = 1'b1;
        2'b10:   pin_o_nxt = 1'b0;
        2'b11:   pin_o_nxt = !pin_o;
        default: pin_o_nxt = pin_o;
      endcase
    end else if (is_pwm) begin
      if (oc_match)      pin_o_nxt = 1'b0;
      else if (ctr_zero) pin_o_nxt = (cc_reg != '0);
    end
    if (mode_chg) pin_o_nxt = 1'b0;
  end

  // Control, compare, flags, pin and interrupt registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode   <= MODE_IC;
      action <= '0;
      irq_en <= 1'b0;
      cc_reg <= '0;
      ocf    <= 1'b0;
      ovf    <= 1'b0;
      pin_o  <= 1'b0;
      pin_oe <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        mode   <= mode_e'(wr_data[1:0]);
        action <= wr_data[3:2];
        irq_en <= wr_data[4];
        pin_oe <= (wr_data[1:0] == MODE_OC) || (wr_data[1:0] == MODE_PWM);
      end
      if (wr_en && (addr == ADDR_CC) && !is_ic) cc_reg <= wr_data;

      if (mode_chg || (status_wr && wr_data[1])) ocf <= 1'b0;
      else if (ocf_set)                          ocf <= 1'b1;

      if (mode_chg || (status_wr && wr_data[2])) ovf <= 1'b0;
      else if (ovf_set)                          ovf <= 1'b1;

      pin_o <= pin_o_nxt;
      irq_o <= irq_en && (icf || ocf || ovf);
    end
  end

  // Register read mux; CC shows the FIFO head in capture mode.
  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_CTRL:   rd_data = CTR_WIDTH'({irq_en, action, mode});
      ADDR_CC:     rd_data = is_ic ? (icf ? mem[rd_ptr] : '0) : cc_reg;
      ADDR_STATUS: rd_data = CTR_WIDTH'(status_vec);
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_scct_ccx_channel.sv
// Directed self-checking bench for scct_ccx_channel (CTR_WIDTH=16, FIFO_DEPTH=4, FILT_LEN=3).
module tb_scct_ccx_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] counter;
  logic        counter_changed;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        irq_o;
  logic        pin_i;
  logic        pin_o;
  logic        pin_oe;

  int checks = 0;
  int errors = 0;
  logic cnt_run = 1'b0;

  scct_ccx_channel #(.CTR_WIDTH(16), .FIFO_DEPTH(4), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .counter(counter), .counter_changed(counter_changed),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .irq_o(irq_o), .pin_i(pin_i), .pin_o(pin_o), .pin_oe(pin_oe)
  );

  always #5 clk = ~clk;

  // One clock; the free-running counter advances just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (cnt_run) begin
      counter = counter + 16'd1;
      counter_changed = 1'b1;
    end else begin
      counter_changed = 1'b0;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    cyc();
    wr_en = 1'b0; wr_data = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic pop();
    addr = 2'd1; rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; pin_i = 1'b0; cnt_run = 1'b0;
    counter = '0; counter_changed = 1'b0; addr = '0; wr_data = '0;
    #3;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; pin_i = 1'b0;
    counter = '0; counter_changed = 1'b0; addr = '0; wr_data = '0;
    #12;
    checks++; if (pin_o !== 1'b0) begin errors++; $display("FAIL rst_pin_o got %b exp 0", pin_o); end
    checks++; if (pin_oe !== 1'b0) begin errors++; $display("FAIL rst_pin_oe got %b exp 0", pin_oe); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq_o); end
    rd(2'd0, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_ctrl got %h exp 0000", v); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_filter();
    logic [15:0] v;
    do_reset();
    wr(2'd0, 16'h0014);
    rd(2'd0, v);
    checks++; if (v !== 16'h0014) begin errors++; $display("FAIL ctrl_read got %h exp 0014", v); end
    counter = 16'h0008; cnt_run = 1'b1;
    cyc(); pin_i = 1'b1; cyc(); cyc(); pin_i = 1'b0;
    repeat (8) cyc();
    rd(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL glitch_status got %h exp 0000", v); end
    counter = 16'h000F;
    cyc();
    pin_i = 1'b1;
    repeat (5) cyc();
    rd(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL filt_early got %h exp 0000", v); end
    cyc();
    rd(2'd2, v);
    checks++; if (v !== 16'h0009) begin errors++; $display("FAIL filt_status got %h exp 0009", v); end
    rd(2'd1, v);
    checks++; if (v !== 16'h0015) begin errors++; $display("FAIL filt_head got %h exp 0015", v); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq_o); end
    cyc();
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq_o); end
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    logic [15:0] exp_v [5];
    do_reset();
    wr(2'd0, 16'h000C);
    counter = 16'h0100; cnt_run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      pin_i = ~pin_i;
      exp_v[i] = counter + 16'd5;
      repeat (7) cyc();
    end
    rd(2'd2, v);
    checks++; if (v !== 16'h0025) begin errors++; $display("FAIL ovf_status got %h exp 0025", v); end
    wr(2'd2, 16'h0004);
    rd(2'd2, v);
    checks++; if (v !== 16'h0021) begin errors++; $display("FAIL ovf_clear got %h exp 0021", v); end
    for (int i = 0; i < 4; i++) begin
      rd(2'd1, v);
      checks++; if (v !== exp_v[i]) begin errors++; $display("FAIL ovf_order%0d got %h exp %h", i, v, exp_v[i]); end
      pop();
    end
    rd(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL drained_status got %h exp 0000", v); end
    rd(2'd1, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL empty_head got %h exp 0000", v); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic [15:0] exp_v [5];
    do_reset();
    wr(2'd0, 16'h000C);
    counter = 16'h0200; cnt_run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      pin_i = ~pin_i;
      exp_v[i] = counter + 16'd5;
      repeat (7) cyc();
    end
    rd(2'd2, v);
    checks++; if (v !== 16'h0021) begin errors++; $display("FAIL full_status got %h exp 0021", v); end
    cyc();
    pin_i = ~pin_i;
    exp_v[4] = counter + 16'd5;
    repeat (5) cyc();
    rd(2'd1, v);
    checks++; if (v !== exp_v[0]) begin errors++; $display("FAIL b2b_head0 got %h exp %h", v, exp_v[0]); end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    rd(2'd2, v);
    checks++; if (v !== 16'h0021) begin errors++; $display("FAIL b2b_status got %h exp 0021", v); end
    for (int i = 1; i < 5; i++) begin
      rd(2'd1, v);
      checks++; if (v !== exp_v[i]) begin errors++; $display("FAIL b2b_order%0d got %h exp %h", i, v, exp_v[i]); end
      pop();
    end
  endtask

  task automatic test_oc();
    logic [15:0] v;
    do_reset();
    wr(2'd0, 16'h000D);
    wr(2'd1, 16'h0100);
    checks++; if (pin_oe !== 1'b1) begin errors++; $display("FAIL oc_oe got %b exp 1", pin_oe); end
    counter = 16'h00FD; cnt_run = 1'b1;
    repeat (3) cyc();
    checks++; if (pin_o !== 1'b0) begin errors++; $display("FAIL oc_pre got %b exp 0", pin_o); end
    cyc();
    checks++; if (pin_o !== 1'b1) begin errors++; $display("FAIL oc_toggle1 got %b exp 1", pin_o); end
    rd(2'd2, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL oc_ocf got %h exp 0002", v); end
    wr(2'd2, 16'h0002);
    rd(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL oc_ocf_clr got %h exp 0000", v); end
    counter = 16'hFFFE;
    repeat (258) cyc();
    checks++; if (pin_o !== 1'b1) begin errors++; $display("FAIL oc_wrap_pre got %b exp 1", pin_o); end
    cyc();
    checks++; if (pin_o !== 1'b0) begin errors++; $display("FAIL oc_toggle2 got %b exp 0", pin_o); end
    wr(2'd2, 16'h0002);
    cnt_run = 1'b0;
    cyc();
    counter = 16'h0100;
    repeat (4) cyc();
    checks++; if (pin_o !== 1'b0) begin errors++; $display("FAIL oc_held got %b exp 0", pin_o); end
    rd(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL oc_held_ocf got %h exp 0000", v); end
    wr(2'd3, 16'h0001);
    checks++; if (pin_o !== 1'b1) begin errors++; $display("FAIL oc_force got %b exp 1", pin_o); end
  endtask

  task automatic test_pwm();
    logic [15:0] v;
    do_reset();
    wr(2'd0, 16'h0002);
    wr(2'd1, 16'h0040);
    checks++; if (pin_oe !== 1'b1) begin errors++; $display("FAIL pwm_oe got %b exp 1", pin_oe); end
    counter = 16'hFFFD; cnt_run = 1'b1;
    repeat (3) cyc();
    checks++; if (pin_o !== 1'b0) begin errors++; $display("FAIL pwm_pre got %b exp 0", pin_o); end
    cyc();
    checks++; if (pin_o !== 1'b1) begin errors++; $display("FAIL pwm_rise got %b exp 1", pin_o); end
    repeat (63) cyc();
    checks++; if (pin_o !== 1'b1) begin errors++; $display("FAIL pwm_high got %b exp 1", pin_o); end
    cyc();
    checks++; if (pin_o !== 1'b0) begin errors++; $display("FAIL pwm_fall got %b exp 0", pin_o); end
    rd(2'd2, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL pwm_ocf got %h exp 0002", v); end
    wr(2'd1, 16'h0000);
    counter = 16'hFFFE;
    repeat (3) cyc();
    checks++; if (pin_o !== 1'b0) begin errors++; $display("FAIL pwm_cc0 got %b exp 0", pin_o); end
    repeat (3) cyc();
    checks++; if (pin_o !== 1'b0) begin errors++; $display("FAIL pwm_cc0_hold got %b exp 0", pin_o); end
    wr(2'd1, 16'h0040);
    counter = 16'hFFFE;
    repeat (3) cyc();
    checks++; if (pin_o !== 1'b1) begin errors++; $display("FAIL pwm_rise2 got %b exp 1", pin_o); end
    wr(2'd0, 16'h0000);
    checks++; if (pin_o !== 1'b0) begin errors++; $display("FAIL modechg_pin got %b exp 0", pin_o); end
    checks++; if (pin_oe !== 1'b0) begin errors++; $display("FAIL modechg_oe got %b exp 0", pin_oe); end
    rd(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL modechg_status got %h exp 0000", v); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    do_reset();
    wr(2'd0, 16'h001C);
    counter = 16'h0300; cnt_run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      pin_i = ~pin_i;
      repeat (7) cyc();
    end
    rd(2'd2, v);
    checks++; if (v !== 16'h0011) begin errors++; $display("FAIL mid_status got %h exp 0011", v); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL mid_irq got %b exp 1", irq_o); end
    cyc();
    pin_i = 1'b1;
    repeat (2) cyc();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL arst_irq got %b exp 0", irq_o); end
    checks++; if (pin_o !== 1'b0 || pin_oe !== 1'b0) begin errors++; $display("FAIL arst_pin got %b%b exp 00", pin_o, pin_oe); end
    rd(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL arst_status got %h exp 0000", v); end
    rd(2'd0, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL arst_ctrl got %h exp 0000", v); end
    pin_i = 1'b0;
    #2;
    rst = 1'b0;
    repeat (10) cyc();
    rd(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL post_rst_status got %h exp 0000", v); end
  endtask

  initial begin
    test_reset();
    test_filter();
    test_overflow();
    test_back_to_back();
    test_oc();
    test_pwm();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
